// File: rtl/int_ctrl_pkg.sv
// Shared constants and helpers for the interrupt controller: register map,
// source count and ID/ISR field positions in the ID/EOI read word.
package int_ctrl_pkg;

    localparam int          NSRC         = 6;
    localparam int          IDW          = 3;
    localparam logic [31:0] BASE_DEFAULT = 32'h00007F20;

    localparam logic [1:0] OFF_MASK  = 2'd0;
    localparam logic [1:0] OFF_MODE  = 2'd1;
    localparam logic [1:0] OFF_PEND  = 2'd2;
    localparam logic [1:0] OFF_IDEOI = 2'd3;

    localparam int ID_LSB  = 0;
    localparam int ISR_LSB = 8;

    typedef logic [NSRC-1:0] src_vec_t;

    // EOI retires the highest-priority (lowest-index) in-service source.
    function automatic src_vec_t clr_lowest(input src_vec_t v);
        return v & (v - src_vec_t'(1));
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-set-bit encoder: returns index+1 of the lowest set bit, 0 when none.
module int_prio_enc #(
    parameter int W  = 6,
    parameter int IW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec_i,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IW'(i + 1);
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Six-source fixed-priority nesting interrupt controller driving HWInt[7:2]
// of the core, configured through the processor bridge register window.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE = BASE_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic [31:0]     PrAddr,
    input  logic [31:0]     PrWD,
    input  logic            PrWe,
    output logic [31:0]     PrRD,
    input  logic            IntAck,
    output logic [NSRC-1:0] HWInt
);

    logic [NSRC-1:0] s1_q, s2_q, s3_q;
    logic [NSRC-1:0] e_q, e_d;
    logic [NSRC-1:0] isr_q, isr_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] hwint_q;

    logic [NSRC-1:0] rise, pending, eligible, ack_vec, e_clr, e_set;
    logic [IDW-1:0]  id, isr_enc, cur;
    logic            hit, wr_mask, wr_mode, wr_pend, wr_eoi;
    logic [1:0]      off;
    logic            unused_bits;

    assign hit     = (PrAddr[31:4] == BASE[31:4]);
    assign off     = PrAddr[3:2];
    assign wr_mask = PrWe && hit && (off == OFF_MASK);
    assign wr_mode = PrWe && hit && (off == OFF_MODE);
    assign wr_pend = PrWe && hit && (off == OFF_PEND);
    assign wr_eoi  = PrWe && hit && (off == OFF_IDEOI);

    assign unused_bits = ^{PrAddr[1:0], PrWD[31:NSRC]};

    assign rise    = s2_q & ~s3_q;
    assign pending = (mode_q & e_q) | (~mode_q & s2_q);

    int_prio_enc #(.W(NSRC), .IW(IDW)) u_cur_enc (
        .vec_i (isr_q),
        .idx_o (isr_enc)
    );

    // An empty ISR places the service level below every source.
    assign cur = (isr_enc == '0) ? IDW'(NSRC) : isr_enc - 1'b1;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NSRC; i++) begin
            eligible[i] = pending[i] & mask_q[i] & (IDW'(i) < cur);
        end
    end

    int_prio_enc #(.W(NSRC), .IW(IDW)) u_id_enc (
        .vec_i (eligible),
        .idx_o (id)
    );

    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < NSRC; i++) begin
            ack_vec[i] = IntAck && (id == IDW'(i + 1));
        end
    end

    // A new edge wins over every clear source in the same cycle.
    always_comb begin
        e_clr = ack_vec;
        if (wr_pend) e_clr = e_clr | PrWD[NSRC-1:0];
        if (wr_mode) e_clr = e_clr | (PrWD[NSRC-1:0] ^ mode_q);
        e_set = rise & mode_q;
        e_d   = (e_q & ~e_clr) | e_set;
    end

    always_comb begin
        isr_d = wr_eoi ? clr_lowest(isr_q) : isr_q;
        isr_d = isr_d | ack_vec;
    end

    always_comb begin
        mask_d = wr_mask ? PrWD[NSRC-1:0] : mask_q;
        mode_d = wr_mode ? PrWD[NSRC-1:0] : mode_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            e_q     <= '0;
            isr_q   <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            hwint_q <= '0;
        end else begin
            s1_q    <= irq_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            e_q     <= e_d;
            isr_q   <= isr_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            hwint_q <= eligible;
        end
    end

    assign HWInt = hwint_q;

    always_comb begin
        PrRD = '0;
        if (hit) begin
            case (off)
                OFF_MASK: PrRD[NSRC-1:0] = mask_q;
                OFF_MODE: PrRD[NSRC-1:0] = mode_q;
                OFF_PEND: PrRD[NSRC-1:0] = pending;
                default: begin
                    PrRD[ISR_LSB +: NSRC] = isr_q;
                    PrRD[ID_LSB +: IDW]   = id;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: a behavioural model predicts HWInt and PrRD,
// a negedge monitor pops and compares; directed scenarios then random traffic.
module tb_int_ctrl;

    localparam logic [31:0] BASE = 32'h00007F20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  irq_in = '0;
    logic [31:0] PrAddr = '0;
    logic [31:0] PrWD = '0;
    logic        PrWe = 1'b0;
    logic        IntAck = 1'b0;
    logic [31:0] PrRD;
    logic [5:0]  HWInt;

    always #5 clk = ~clk;

    int_ctrl #(.BASE(BASE)) dut (
        .clk    (clk),
        .reset  (rst_n),
        .irq_in (irq_in),
        .PrAddr (PrAddr),
        .PrWD   (PrWD),
        .PrWe   (PrWe),
        .PrRD   (PrRD),
        .IntAck (IntAck),
        .HWInt  (HWInt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0]  hw_q[$];
    logic [31:0] rd_q[$];
    bit          rd_pend = 1'b0;

    // Reference state: sampled irq history (h0 newest), registers, edge latches.
    logic [5:0] m_mask = '0, m_mode = '0, m_lat = '0, m_isr = '0;
    logic [5:0] m_h0 = '0, m_h1 = '0, m_h2 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] m_pending();
        logic [5:0] p;
        for (int i = 0; i < 6; i++) p[i] = m_mode[i] ? m_lat[i] : m_h1[i];
        return p;
    endfunction

    function automatic int m_level();
        for (int i = 0; i < 6; i++) if (m_isr[i]) return i;
        return 6;
    endfunction

    function automatic logic [5:0] m_elig();
        logic [5:0] p, e;
        int lvl;
        p = m_pending();
        lvl = m_level();
        for (int i = 0; i < 6; i++) e[i] = p[i] && m_mask[i] && (i < lvl);
        return e;
    endfunction

    function automatic int m_id();
        logic [5:0] e;
        e = m_elig();
        for (int i = 0; i < 6; i++) if (e[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'd0:    return {26'd0, m_mask};
            2'd1:    return {26'd0, m_mode};
            2'd2:    return {26'd0, m_pending()};
            default: return ({26'd0, m_isr} << 8) | 32'(m_id());
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [5:0] rise;
        int  id, off;
        bit  wr;
        if (!rst_n) begin
            m_mask = '0; m_mode = '0; m_lat = '0; m_isr = '0;
            m_h0 = '0; m_h1 = '0; m_h2 = '0;
            hw_q.delete();
        end else begin
            hw_q.push_back(m_elig());
            id   = m_id();
            wr   = PrWe && (PrAddr[31:4] == BASE[31:4]);
            off  = int'(PrAddr[3:2]);
            rise = m_h1 & ~m_h2;
            for (int i = 0; i < 6; i++) begin
                if (rise[i] && m_mode[i])
                    m_lat[i] = 1'b1;
                else if ((wr && off == 2 && PrWD[i]) || (IntAck && id == i + 1) ||
                         (wr && off == 1 && PrWD[i] != m_mode[i]))
                    m_lat[i] = 1'b0;
            end
            if (wr && off == 3) begin
                for (int i = 0; i < 6; i++) begin
                    if (m_isr[i]) begin
                        m_isr[i] = 1'b0;
                        break;
                    end
                end
            end
            if (IntAck && id != 0) m_isr[id-1] = 1'b1;
            if (wr && off == 0) m_mask = PrWD[5:0];
            if (wr && off == 1) m_mode = PrWD[5:0];
            m_h2 = m_h1;
            m_h1 = m_h0;
            m_h0 = irq_in;
        end
    end

    always @(negedge clk) begin : monitor
        logic [5:0]  hexp;
        logic [31:0] rexp;
        if (hw_q.size() > 0) begin
            hexp = hw_q.pop_front();
            check("hwint_sb", 32'(HWInt), 32'(hexp));
        end
        if (rd_pend && rd_q.size() > 0) begin
            rexp = rd_q.pop_front();
            check("prrd_sb", PrRD, rexp);
        end
    end

    // One bus cycle: drive after the edge, let the monitor see PrRD, pass one edge.
    task automatic cyc(input logic [31:0] a, input bit we, input logic [31:0] wd, input bit ack);
        PrAddr = a; PrWe = we; PrWD = wd; IntAck = ack;
        rd_q.push_back(m_read(a));
        rd_pend = 1'b1;
        @(negedge clk);
        #1 rd_pend = 1'b0;
        @(posedge clk);
        #1;
        PrWe = 1'b0; IntAck = 1'b0;
    endtask

    task automatic idle();
        cyc(BASE, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic ack();
        cyc(BASE + 32'hC, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        cyc(BASE + 32'(off) * 4, 1'b1, d, 1'b0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        PrAddr = a; PrWe = 1'b0;
        #1 check(name, PrRD, exp);
        cyc(a, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic hw_chk(input string name, input logic [5:0] exp);
        check(name, 32'(HWInt), 32'(exp));
    endtask

    task automatic pulse_wait(input logic [5:0] bits, input int n);
        irq_in = bits;
        idle();
        irq_in = '0;
        repeat (n - 1) idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d;
        int k;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        hw_chk("reset_hw", 6'h00);
        rd_chk("reset_mask", BASE, 32'h0);
        rd_chk("reset_ideoi", BASE + 32'hC, 32'h0);

        // edge detect, latency and acknowledge
        wr(0, 32'h3F);
        wr(1, 32'h3F);
        pulse_wait(6'h04, 3);
        hw_chk("t1_before_latency", 6'h00);
        idle();
        hw_chk("t1_hw", 6'h04);
        rd_chk("t1_pend", BASE + 32'h8, 32'h4);
        rd_chk("t1_id", BASE + 32'hC, 32'h3);
        ack();
        rd_chk("t1_isr", BASE + 32'hC, 32'h400);
        hw_chk("t1_hw_after_ack", 6'h00);
        rd_chk("t1_pend_clr", BASE + 32'h8, 32'h0);

        // nesting
        pulse_wait(6'h10, 4);
        hw_chk("t2_lower_held", 6'h00);
        pulse_wait(6'h01, 4);
        hw_chk("t2_higher_nests", 6'h01);
        ack();
        rd_chk("t2_isr_nested", BASE + 32'hC, 32'h500);
        wr(3, 32'h0);
        rd_chk("t2_isr_eoi1", BASE + 32'hC, 32'h400);
        hw_chk("t2_still_held", 6'h00);
        wr(3, 32'h0);
        rd_chk("t2_id_after_eoi2", BASE + 32'hC, 32'h5);
        hw_chk("t2_hw_released", 6'h10);

        // level mode
        wr(1, 32'h0);
        wr(0, 32'h2);
        irq_in = 6'h02;
        idle(); idle();
        hw_chk("t3_level_early", 6'h00);
        idle();
        hw_chk("t3_level_hw", 6'h02);
        wr(2, 32'h2);
        idle();
        hw_chk("t3_w1c_noeffect", 6'h02);
        irq_in = '0;
        idle(); idle();
        hw_chk("t3_drop_early", 6'h02);
        idle();
        hw_chk("t3_drop_hw", 6'h00);

        // masking
        wr(0, 32'h0);
        wr(1, 32'h3F);
        pulse_wait(6'h08, 4);
        hw_chk("t4_masked", 6'h00);
        rd_chk("t4_pend", BASE + 32'h8, 32'h8);
        wr(0, 32'h8);
        idle();
        hw_chk("t4_unmasked", 6'h08);
        wr(2, 32'h8);
        idle();
        hw_chk("t4_w1c", 6'h00);

        // set/clear collision, spurious ack, out-of-window access
        pulse_wait(6'h08, 4);
        ack();
        irq_in = 6'h20;
        idle(); idle();
        wr(2, 32'h20);
        irq_in = '0;
        rd_chk("t5_set_wins", BASE + 32'h8, 32'h20);
        ack();
        rd_chk("t5_spurious_ack", BASE + 32'hC, 32'h800);
        rd_chk("t5_oow_read", BASE + 32'h10, 32'h0);
        cyc(BASE + 32'h10, 1'b1, 32'h3F, 1'b0);
        cyc(BASE + 32'h1C, 1'b1, 32'h0, 1'b0);
        rd_chk("t5_oow_mask", BASE, 32'h8);
        rd_chk("t5_oow_eoi", BASE + 32'hC, 32'h800);

        // asynchronous reset mid-service
        wr(3, 32'h0);
        wr(2, 32'h3F);
        wr(0, 32'h3F);
        pulse_wait(6'h01, 4);
        ack();
        hw_chk("t6_pre_reset", 6'h01);
        PrAddr = BASE + 32'hC;
        #1 rst_n = 1'b0;
        #1;
        hw_chk("t6_async_hw", 6'h00);
        check("t6_async_rd", PrRD, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd_chk("t6_mask", BASE, 32'h0);
        rd_chk("t6_mode", BASE + 32'h4, 32'h0);
        rd_chk("t6_pend", BASE + 32'h8, 32'h0);
        rd_chk("t6_ideoi", BASE + 32'hC, 32'h0);

        // randomized traffic against the model
        wr(0, 32'h3F);
        for (int n = 0; n < 3000; n++) begin
            irq_in = irq_in ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
            k = $urandom_range(0, 9);
            if (k < 8)       a = BASE + 32'($urandom_range(0, 3)) * 4;
            else if (k == 8) a = BASE + 32'h10 + 32'($urandom_range(0, 3)) * 4;
            else             a = $urandom & 32'hFFFF_FFFC;
            d = $urandom;
            if (a == BASE) d = d | 32'h2D;
            cyc(a, ($urandom_range(0, 3) == 0), d, ($urandom_range(0, 5) == 0));
        end
        irq_in = '0;
        repeat (4) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Programmable interrupt controller for the pipelined MIPS core. It collects six external device interrupt lines, latches and masks them, and nests them by fixed priority. It drives the core's HWInt[7:2] inputs. It is configured through the processor bridge bus (PrAddr/PrWD/PrWe/PrRD) as a memory-mapped device. The core pulses IntAck when it takes a hardware interrupt; the handler ends service with an EOI write.

Parameters:
NSRC, 6, number of interrupt sources (maps to HWInt[7:2]; fixed 6 for this core)
BASE, 32'h00007F20, word-aligned base address of the 16-byte register window

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
irq_in  in  6  raw device interrupt lines, asynchronous to clk
PrAddr  in  32  bridge address from core
PrWD  in  32  bridge write data
PrWe  in  1  bridge write enable
PrRD  out  32  bridge read data, combinational
IntAck  in  1  one-cycle pulse: core entered the hardware-interrupt handler
HWInt  out  6  registered eligible-interrupt mask to core HWInt[7:2]; bit i = source i

Behaviour:
- Register window. hit = (PrAddr[31:4] == BASE[31:4]). Offset = PrAddr[3:2].
  - 0 MASK: RW, bits[5:0], 1 = enabled.
  - 1 MODE: RW, bits[5:0], 1 = edge-triggered, 0 = level.
  - 2 PEND: read gives pending[5:0]; write-1-to-clear of edge latches.
  - 3 ID/EOI: read gives {ISR[5:0] at bits 13:8, ID at bits 2:0}; any write is EOI.
- Reads: unused bits read 0. Reads outside the window, or with hit=0, return 32'h0. Writes only when PrWe && hit.
- Synchronizer: s1<=irq_in; s2<=s1; s3<=s2. rise = s2 & ~s3.
- Pending per source:
  - Edge mode: latch E[i] is set on rise[i], cleared by PEND W1C or by IntAck selecting i. Set wins over clear in the same cycle.
  - Level mode: pending[i] = s2[i] live. Not clearable, no latch.
- Mode change: writing MODE clears E[i] for every bit whose mode value changes.
- Priority: source 0 is highest. ISR[5:0] is the in-service register. cur = index of lowest set ISR bit, or 6 if ISR is empty.
- Eligibility: eligible[i] = pending[i] & MASK[i] & (i < cur).
- ID: ID = (lowest set eligible index) + 1, or 0 if none.
- HWInt <= eligible every cycle (one-cycle register).
- Latency: irq_in high before edge k gives HWInt high after edge k+3 in edge mode (E set at k+2), and after edge k+2 in level mode.
- IntAck (sampled on edge):
  - If ID != 0: set ISR[ID-1] and clear E[ID-1].
  - If ID == 0: spurious, no state change.
  - IntAck and PEND W1C on the same source in the same cycle: cleared.
- EOI write: clears the lowest set ISR bit. No-op if ISR is empty. EOI and IntAck in the same cycle: EOI clears first, then IntAck sets using the ID computed from the pre-edge state.
- Nesting: a higher-priority source can raise HWInt while a lower one is in service. Equal- and lower-priority sources are held off until EOI.
- Reset (reset=0, asynchronous):
  - MASK=0, MODE=0, E=0, ISR=0, s1/s2/s3=0, HWInt=0.
  - PrRD is then 0 for every offset except a MODE/MASK read, which is also 0.
  - Reset mid-service drops all in-service and pending state.

Decomposition:
- Shared package (int_ctrl_pkg): register offsets OFF_MASK=2'd0, OFF_MODE=2'd1, OFF_PEND=2'd2, OFF_IDEOI=2'd3; NSRC; ID field positions.
- One sub-module: int_prio_enc, a combinational lowest-set-bit encoder returning index+1 (0 = none). It is instantiated twice: once for eligible→ID and once for ISR→cur.
- Everything else stays flat in int_ctrl.

Test Plan:
1. Reset, then MASK=6'h3F and MODE=6'h3F. Pulse irq_in[2] for one cycle → HWInt=6'b000100 three edges after sampling, PEND reads 32'h4, ID reads 3. IntAck → ISR=6'b000100, PEND=0, HWInt=0 next cycle.
2. Nesting, continuing from 1: pulse irq_in[4] → HWInt stays 0 (lower priority). Pulse irq_in[0] → HWInt=6'b000001. IntAck → ISR=6'b000101. EOI → ISR=6'b000100, HWInt still 0. EOI → ISR=0, HWInt=6'b010000, ID=5.
3. Level mode: MODE=0, MASK=6'h02, hold irq_in[1] high → HWInt=6'b000010 two edges later. W1C PEND=32'h2 → no effect. Drop irq_in[1] → HWInt=0 after the same latency.
4. Masking: MASK=0, MODE=6'h3F, pulse irq_in[3] → HWInt=0, PEND=32'h8. Write MASK=6'h08 → HWInt=6'b001000 next edge. W1C 32'h8 → HWInt=0.
5. Collision: edge on source 5 in the same cycle as a W1C of bit 5 → PEND bit 5 stays 1. IntAck with ID=0 → ISR unchanged. Address BASE+32'h10 → PrRD=0 and writes are ignored.
6. Assert reset low asynchronously mid-cycle with ISR=6'h01 and HWInt≠0 → all outputs 0 immediately, before the next edge. Registers read 0 after release.
